pe_cfg_loader: RTL and testbench

- Initiator side of the PE configuration interface: the master that drives `PE_inst`, `init` and `run` into a row of PEs.
- On a start command it fetches NUM_PE×ctx_num instruction words from configuration memory and streams them into each PE's config buffer with one-hot init strobes. It then drives the shared `run` for run_len cycles.
- Sits between the array-level controller / config SRAM and the PE array.

---
 rtl/pe_cfg_loader_pkg.sv | 28 ++
 rtl/pe_cfg_loader_addr_gen.sv | 82 ++++++++
 rtl/pe_cfg_loader.sv | 156 +++++++++++++++
 tb/tb_pe_cfg_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_cfg_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_cfg_loader_pkg
// Purpose  : Shared PE-array parameters plus the state encoding of the
//            PE configuration loader.
//            PE_INST_W    : width of one PE instruction word
//                           (fu_opcode 4 | switch_9x7 28 | switch_5x4 12 |
//                            reg_file_sel 4)
//            BUFFER_DEPTH : per-PE config buffer depth (max contexts)
// Revision : 1.0 - initial release
// ============================================================================
package pe_cfg_loader_pkg;

    localparam int PE_INST_W    = 48;
    localparam int BUFFER_DEPTH = 4;

    // Loader sequence: IDLE -> CLEAR -> LOAD -> DRAIN -> RUN -> DONE -> IDLE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage : pe_cfg_loader_pkg
`default_nettype wire

// File: rtl/pe_cfg_loader_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : pe_cfg_loader_addr_gen
// Purpose  : Read-address generator for the config loader. Walks the
//            pe-major / ctx-minor nested counters while issue_en is high and
//            delays the pe index by one cycle so it lines up with mem_rdata.
// Ports    : clk, rst       clock, async active-high reset
//            issue_en       one read issued this cycle (LOAD state)
//            flush          drop the read in flight (abort)
//            base           latched first config address
//            ctx_num        latched contexts per PE (1..DEPTH)
//            mem_addr       read address for this cycle
//            last_issue     this cycle issues the final read
//            rd_valid       mem_rdata carries a wanted word this cycle
//            rd_pe          PE that the word in mem_rdata belongs to
// Revision : 1.0 - initial release
// ============================================================================
module pe_cfg_loader_addr_gen #(
    parameter int NUM_PE = 4,
    parameter int ADDR_W = 8,
    parameter int CTX_W  = 3,
    parameter int PE_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_en,
    input  logic              flush,
    input  logic [ADDR_W-1:0] base,
    input  logic [CTX_W-1:0]  ctx_num,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              last_issue,
    output logic              rd_valid,
    output logic [PE_W-1:0]   rd_pe
);

    logic [PE_W-1:0]   r_pe;
    logic [CTX_W-1:0]  r_ctx;
    // Because issue order is pe-major with a stride of ctx_num, the address
    // offset pe*ctx_num + ctx is simply the running read count.
    logic [ADDR_W-1:0] r_offset;
    logic              w_ctx_last;

    assign w_ctx_last = (r_ctx == ctx_num - CTX_W'(1));
    assign last_issue = issue_en && w_ctx_last && (r_pe == PE_W'(NUM_PE - 1));
    // Wraps naturally modulo 2^ADDR_W.
    assign mem_addr   = issue_en ? (base + r_offset) : '0;

    // LOAD is one contiguous burst, so counters simply rest at zero whenever
    // no read is being issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pe     <= '0;
            r_ctx    <= '0;
            r_offset <= '0;
        end else if (!issue_en) begin
            r_pe     <= '0;
            r_ctx    <= '0;
            r_offset <= '0;
        end else begin
            r_offset <= r_offset + ADDR_W'(1);
            if (w_ctx_last) begin
                r_ctx <= '0;
                r_pe  <= r_pe + PE_W'(1);
            end else begin
                r_ctx <= r_ctx + CTX_W'(1);
            end
        end
    end

    // One stage matching the 1-cycle memory read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_pe    <= '0;
        end else begin
            rd_valid <= issue_en && !flush;
            rd_pe    <= r_pe;
        end
    end

endmodule : pe_cfg_loader_addr_gen
`default_nettype wire

// File: rtl/pe_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : pe_cfg_loader
// Purpose  : Initiator of the PE configuration interface. On start, clears
//            the PEs, streams NUM_PE*ctx_num words from config memory into
//            the PE buffers with one-hot init strobes, then holds run for
//            run_len cycles and pulses done.
// Ports    : clk, rst              clock, async active-high reset
//            start, abort          command pulse / terminate
//            base_addr, ctx_num,   operands, latched when start is accepted
//            run_len
//            mem_rd_en, mem_addr,  config memory read port (1-cycle latency)
//            mem_rdata
//            pe_clr, pe_inst,      PE array interface
//            pe_init, pe_run
//            busy, done, err       status
// Revision : 1.0 - initial release
// ============================================================================
module pe_cfg_loader
    import pe_cfg_loader_pkg::*;
#(
    parameter int INST_W = PE_INST_W,
    parameter int NUM_PE = 4,
    parameter int DEPTH  = BUFFER_DEPTH,
    parameter int ADDR_W = 8,
    parameter int RUN_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [$clog2(DEPTH):0]   ctx_num,
    input  logic [RUN_W-1:0]         run_len,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [INST_W-1:0]        mem_rdata,
    output logic                     pe_clr,
    output logic [INST_W-1:0]        pe_inst,
    output logic [NUM_PE-1:0]        pe_init,
    output logic                     pe_run,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int CTX_W = $clog2(DEPTH) + 1;
    localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_base;
    logic [CTX_W-1:0]  r_ctx_num;
    logic [RUN_W-1:0]  r_run_cnt;
    logic              r_drain;
    logic              w_cmd_ok, w_accept, w_abort;
    logic              w_last_issue, w_rd_valid;
    logic [PE_W-1:0]   w_rd_pe;

    assign w_cmd_ok = (ctx_num != '0) && (ctx_num <= CTX_W'(DEPTH)) &&
                      (run_len != '0) && (run_len <= RUN_W'(ctx_num));
    // abort beats start in IDLE; elsewhere it forces IDLE.
    assign w_accept = (r_state == ST_IDLE) && start && !abort && w_cmd_ok;
    assign w_abort  = (r_state != ST_IDLE) && abort;

    pe_cfg_loader_addr_gen #(
        .NUM_PE (NUM_PE),
        .ADDR_W (ADDR_W),
        .CTX_W  (CTX_W),
        .PE_W   (PE_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (mem_rd_en),
        .flush      (w_abort),
        .base       (r_base),
        .ctx_num    (r_ctx_num),
        .mem_addr   (mem_addr),
        .last_issue (w_last_issue),
        .rd_valid   (w_rd_valid),
        .rd_pe      (w_rd_pe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        mem_rd_en = 1'b0;
        pe_clr    = 1'b0;
        pe_run    = 1'b0;
        done      = 1'b0;
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_CLEAR;
            ST_CLEAR: begin
                pe_clr = 1'b1;
                w_next = ST_LOAD;
            end
            ST_LOAD: begin
                mem_rd_en = 1'b1;
                if (w_last_issue) w_next = ST_DRAIN;
            end
            // Two cycles: memory latency plus the pe_inst register.
            ST_DRAIN: if (r_drain) w_next = ST_RUN;
            ST_RUN: begin
                pe_run = 1'b1;
                if (r_run_cnt == RUN_W'(1)) w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default:  w_next = ST_IDLE;
        endcase
        if (w_abort) w_next = ST_IDLE;
    end

    // Operand latch, run countdown and drain phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base    <= '0;
            r_ctx_num <= '0;
            r_run_cnt <= '0;
            r_drain   <= 1'b0;
            err       <= 1'b0;
        end else begin
            err     <= (r_state == ST_IDLE) && start && !abort && !w_cmd_ok;
            r_drain <= (r_state == ST_DRAIN) && !r_drain;
            if (w_accept) begin
                r_base    <= base_addr;
                r_ctx_num <= ctx_num;
                r_run_cnt <= run_len;
            end else if (r_state == ST_RUN && r_run_cnt != '0) begin
                r_run_cnt <= r_run_cnt - RUN_W'(1);
            end
        end
    end

    // Data register: pe_inst and its one-hot strobe land together, two
    // cycles after the read was issued. An abort discards the returning word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_inst <= '0;
            pe_init <= '0;
        end else if (w_rd_valid && !w_abort) begin
            pe_inst <= mem_rdata;
            pe_init <= NUM_PE'(1) << w_rd_pe;
        end else begin
            pe_init <= '0;
        end
    end

endmodule : pe_cfg_loader
`default_nettype wire

// File: tb/tb_pe_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_cfg_loader
// Purpose  : Directed self-checking bench for pe_cfg_loader. A negedge
//            monitor logs reads, init strobes and status pulses; each
//            scenario compares the log against hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_cfg_loader;

    localparam int INST_W = 48;
    localparam int NUM_PE = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;
    localparam int RUN_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [2:0]        ctx_num = '0;
    logic [RUN_W-1:0]  run_len = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_rdata = '0;
    logic              pe_clr;
    logic [INST_W-1:0] pe_inst;
    logic [NUM_PE-1:0] pe_init;
    logic              pe_run, busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    pe_cfg_loader #(
        .INST_W (INST_W), .NUM_PE (NUM_PE), .DEPTH (DEPTH),
        .ADDR_W (ADDR_W), .RUN_W (RUN_W)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .abort (abort),
        .base_addr (base_addr), .ctx_num (ctx_num), .run_len (run_len),
        .mem_rd_en (mem_rd_en), .mem_addr (mem_addr), .mem_rdata (mem_rdata),
        .pe_clr (pe_clr), .pe_inst (pe_inst), .pe_init (pe_init),
        .pe_run (pe_run), .busy (busy), .done (done), .err (err)
    );

    always #5 clk = ~clk;

    function automatic logic [INST_W-1:0] word(input logic [ADDR_W-1:0] a);
        return {16'hC0DE, 24'h0, a};
    endfunction

    // Config memory: one-cycle read latency, junk when not read.
    always @(posedge clk)
        mem_rdata <= mem_rd_en ? word(mem_addr) : 48'hDEAD_BEEF_0BAD;

    // ---------------- monitor ----------------
    int cyc, start_cyc, clr_cyc, first_init_cyc, done_cyc;
    int done_cnt, err_cnt, run_cnt, busy_cnt, viol;
    logic [ADDR_W-1:0] rd_q[$];
    logic [NUM_PE-1:0] init_q[$];
    logic [INST_W-1:0] inst_q[$];

    task automatic mon_clear();
        cyc = 0; start_cyc = -1; clr_cyc = -1; first_init_cyc = -1;
        done_cyc = -1; done_cnt = 0; err_cnt = 0; run_cnt = 0;
        busy_cnt = 0; viol = 0;
        rd_q.delete(); init_q.delete(); inst_q.delete();
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (start && !busy && start_cyc < 0) start_cyc = cyc;
        if (pe_clr) clr_cyc = cyc;
        if (mem_rd_en) rd_q.push_back(mem_addr);
        if (pe_init != '0) begin
            init_q.push_back(pe_init);
            inst_q.push_back(pe_inst);
            if (first_init_cyc < 0) first_init_cyc = cyc;
        end
        if (pe_run) run_cnt = run_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (err) err_cnt = err_cnt + 1;
        if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
        if ((pe_run && pe_init != '0) || $countones(pe_init) > 1) viol = viol + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] b, input logic [2:0] c,
                               input logic [15:0] r);
        @(posedge clk); #1;
        base_addr = b; ctx_num = c; run_len = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_run(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (pe_run) seen = 1'b1;
        end
    endtask

    // Check a whole sequence: nr reads from base, ctx contexts per PE.
    task automatic check_seq(input string tag, input logic [7:0] b,
                             input int ctx, input int runl);
        int n;
        logic [7:0] a;
        n = NUM_PE * ctx;
        check({tag, "_nrd"}, rd_q.size(), n);
        check({tag, "_ninit"}, init_q.size(), n);
        for (int i = 0; i < n; i++) begin
            a = b + 8'(i);
            check($sformatf("%s_rd%0d", tag, i),
                  (i < rd_q.size()) ? rd_q[i] : 8'hXX, a);
            check($sformatf("%s_init%0d", tag, i),
                  (i < init_q.size()) ? init_q[i] : 4'hX, 4'b1 << (i / ctx));
            check($sformatf("%s_inst%0d", tag, i),
                  (i < inst_q.size()) ? inst_q[i] : 48'hX, word(a));
        end
        check({tag, "_run"}, run_cnt, runl);
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_lat"}, done_cyc - start_cyc, 1 + n + 2 + runl + 1);
        check({tag, "_clr2init"}, first_init_cyc - clr_cyc, 3);
        check({tag, "_viol"}, viol, 0);
        check({tag, "_err"}, err_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        logic [2:0]  rj_ctx [4] = '{3'd0, 3'd5, 3'd2, 3'd2};
        logic [15:0] rj_run [4] = '{16'd1, 16'd1, 16'd0, 16'd3};

        mon_clear();
        repeat (3) @(posedge clk);
        #2;
        check("rst_ctrl", {mem_rd_en, mem_addr, pe_clr, pe_init, pe_run,
                           busy, done, err}, 64'h0);
        check("rst_inst", pe_inst, 48'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full load
        mon_clear();
        pulse_start(8'h10, 3'd4, 16'd4);
        repeat (35) @(posedge clk);
        check_seq("full", 8'h10, 4, 4);
        check("full_busy", busy_cnt, 24);
        check("full_hold", pe_inst, word(8'h1F));

        // Address wrap
        mon_clear();
        pulse_start(8'hFE, 3'd2, 16'd2);
        repeat (25) @(posedge clk);
        check_seq("wrap", 8'hFE, 2, 2);

        // Rejected commands
        for (int k = 0; k < 4; k++) begin
            mon_clear();
            pulse_start(8'h20, rj_ctx[k], rj_run[k]);
            repeat (3) @(posedge clk);
            check($sformatf("rej%0d_err", k), err_cnt, 1);
            check($sformatf("rej%0d_busy", k), busy_cnt, 0);
            check($sformatf("rej%0d_rd", k), rd_q.size(), 0);
        end

        // start with abort in IDLE: nothing happens
        mon_clear();
        @(posedge clk); #1;
        base_addr = 8'h30; ctx_num = 3'd1; run_len = 16'd1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        check("sa_busy", busy_cnt, 0);
        check("sa_err", err_cnt, 0);

        // Abort during 3rd LOAD cycle
        mon_clear();
        pulse_start(8'h50, 3'd4, 16'd2);
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("ab_strobes", {mem_rd_en, pe_init, pe_run, busy}, 0);
        repeat (6) @(posedge clk);
        check("ab_nrd", rd_q.size(), 3);
        check("ab_ninit", init_q.size(), 1);
        check("ab_init0", (init_q.size() > 0) ? init_q[0] : 4'hX, 4'b0001);
        check("ab_done", done_cnt, 0);

        // start during RUN is ignored
        mon_clear();
        pulse_start(8'h40, 3'd2, 16'd2);
        wait_run(seen);
        check("ir_seen", seen, 1);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        check("ir_done", done_cnt, 1);
        check("ir_nrd", rd_q.size(), 8);

        // New start after done: clear precedes loads
        mon_clear();
        pulse_start(8'h60, 3'd1, 16'd1);
        repeat (15) @(posedge clk);
        check("re_clr", clr_cyc - start_cyc, 1);
        check_seq("re", 8'h60, 1, 1);

        // Async reset mid-RUN, unaligned to the clock
        mon_clear();
        pulse_start(8'h10, 3'd4, 16'd4);
        wait_run(seen);
        check("ar_seen", seen, 1);
        #3 rst = 1'b1;
        #1;
        check("ar_out", {mem_rd_en, pe_clr, pe_init, pe_run, busy, done, err}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("ar_done", done_cnt, 0);
        mon_clear();
        pulse_start(8'h10, 3'd4, 16'd4);
        repeat (35) @(posedge clk);
        check_seq("ar2", 8'h10, 4, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pe_cfg_loader
`default_nettype wire
